// File: rtl/usb_crc_pkg.sv
// Shared types and constants for the serial USB CRC engine.
//   crc_state_t : engine FSM state encoding
//   CRC5_*      : token CRC generator polynomial and good-packet residue
//   CRC16_*     : data CRC generator polynomial and good-packet residue
package usb_crc_pkg;

  typedef enum logic [1:0] {IDLE, DATA, APPEND, DONE} crc_state_t;

  localparam logic [4:0]  CRC5_POLY  = 5'h05;
  localparam logic [4:0]  CRC5_RES   = 5'h0C;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_RES  = 16'h800D;

endpackage

// File: rtl/usb_crc_lfsr_step.sv
// One serial step of a Galois-style CRC register (combinational).
//   q      : current register value
//   d      : incoming data bit
//   q_next : register value after shifting d in
module usb_crc_lfsr_step
  import usb_crc_pkg::*;
#(
  parameter int unsigned      WIDTH = 5,
  parameter logic [WIDTH-1:0] POLY  = CRC5_POLY
) (
  input  logic [WIDTH-1:0] q,
  input  logic             d,
  output logic [WIDTH-1:0] q_next
);

  logic fb;

  assign fb     = d ^ q[WIDTH-1];
  assign q_next = {q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/usb_crc_engine.sv
// Serial USB CRC engine (CRC5 or CRC16) for RX checking and TX generation.
//   clk, n_rst     : clock, asynchronous active-low reset
//   crc_clear      : synchronous clear back to IDLE with q = INIT
//   mode_tx        : sampled on the first bit of a packet (1 = append CRC, 0 = check)
//   shift_enable   : one data bit valid this cycle on d_orig
//   eop            : end of data field (RX: after CRC bits, TX: after payload)
//   crc_value      : current CRC register
//   crc_bit        : appended TX bit, qualified by crc_bit_valid
//   crc_valid      : one-cycle pulse, RX verdict ready
//   crc_ok         : RX verdict, held until clear or next packet start
//   busy           : packet in progress (DATA or APPEND)
module usb_crc_engine
  import usb_crc_pkg::*;
#(
  parameter int unsigned      WIDTH   = 5,
  parameter logic [WIDTH-1:0] POLY    = CRC5_POLY,
  parameter logic [WIDTH-1:0] INIT    = '1,
  parameter logic [WIDTH-1:0] RESIDUE = CRC5_RES,
  parameter int unsigned      CNT_W   = 11
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             crc_clear,
  input  logic             mode_tx,
  input  logic             shift_enable,
  input  logic             d_orig,
  input  logic             eop,
  output logic [WIDTH-1:0] crc_value,
  output logic             crc_bit,
  output logic             crc_bit_valid,
  output logic             crc_valid,
  output logic             crc_ok,
  output logic             busy
);

  localparam int unsigned KW = $clog2(WIDTH + 1);

  crc_state_t       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [KW-1:0]    k_q, k_d;
  logic             tx_q, tx_d;
  logic             ok_q, ok_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] step_in, step_out, q_sel;

  // A packet started from DONE steps from INIT, not from the held remainder.
  assign step_in = (state_q == DONE) ? INIT : q_q;

  usb_crc_lfsr_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_step (
    .q      (step_in),
    .d      (d_orig),
    .q_next (step_out)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    tx_d    = tx_q;
    ok_d    = ok_q;
    valid_d = 1'b0;
    if (crc_clear) begin
      state_d = IDLE;
      q_d     = INIT;
      cnt_d   = '0;
      k_d     = '0;
      tx_d    = 1'b0;
      ok_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (shift_enable) begin
            q_d     = step_out;
            cnt_d   = CNT_W'(1);
            k_d     = '0;
            tx_d    = mode_tx;
            ok_d    = 1'b0;
            state_d = DATA;
          end
        end
        DATA: begin
          if (shift_enable) begin
            q_d   = step_out;
            cnt_d = cnt_inc;
          end
          // Verdict sees the bit shifted in this same cycle.
          if (eop) begin
            if (tx_q) begin
              state_d = APPEND;
              k_d     = '0;
            end else begin
              state_d = DONE;
              valid_d = 1'b1;
              ok_d    = (q_d == RESIDUE) && (cnt_d >= CNT_W'(WIDTH));
            end
          end
        end
        APPEND: begin
          if (shift_enable) begin
            if (k_q == KW'(WIDTH - 1)) begin
              state_d = DONE;
              k_d     = '0;
            end else begin
              k_d = k_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      q_q     <= INIT;
      cnt_q   <= '0;
      k_q     <= '0;
      tx_q    <= 1'b0;
      ok_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      tx_q    <= tx_d;
      ok_q    <= ok_d;
      valid_q <= valid_d;
    end
  end

  // Appended bits go out MSB first, inverted; shifting avoids a variable part-select.
  assign q_sel         = q_q << k_q;
  assign crc_bit_valid = (state_q == APPEND) && shift_enable;
  assign crc_bit       = crc_bit_valid & ~q_sel[WIDTH-1];

  assign crc_value = q_q;
  assign crc_valid = valid_q;
  assign crc_ok    = ok_q;
  // DONE only holds a result; the engine is free to take the next packet.
  assign busy      = (state_q == DATA) || (state_q == APPEND);

endmodule
